// File: rtl/rv32_mem_arb_pkg.sv
// Shared types for the RV32 instruction/data memory arbiter: FSM state
// encoding, grant encodings and the reset value of the round-robin pointer.
package rv32_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Pointer starts on the fetch side so the data side wins the first tie.
  localparam logic LAST_GRANT_RST = GNT_I;

endpackage

// File: rtl/rv32_arb_pick2.sv
// Combinational two-way picker between fetch and data requests.
// RV32_MEM_ARB_RR_EN selects round-robin ties; otherwise data wins every tie.
module rv32_arb_pick2
  import rv32_mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_sel
);

  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_sel   = GNT_I;
    if (i_req && d_req) begin
`ifdef RV32_MEM_ARB_RR_EN
      gnt_sel = (last_grant == GNT_I) ? GNT_D : GNT_I;
`else
      gnt_sel = GNT_D;
`endif
    end else if (d_req) begin
      gnt_sel = GNT_D;
    end else if (i_req) begin
      gnt_sel = GNT_I;
    end else begin
      // No request: gnt_sel is a don't-care, so just echo the pointer.
      gnt_sel = last_grant;
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one single-port memory between the RV32 fetch and load/store ports,
// one transaction at a time. Define RV32_MEM_ARB_RR_EN for round-robin ties.
module rv32_mem_arbiter
  import rv32_mem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output arb_state_t      dbg_state
);

  arb_state_t      state_q, state_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [DW/8-1:0] m_wstrb_q, m_wstrb_d;
  logic            gnt_valid, gnt_sel, last_grant, grant;

  assign grant = (state_q == IDLE) && gnt_valid;

`ifdef RV32_MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant) last_grant_d = gnt_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= LAST_GRANT_RST;
    else          last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = LAST_GRANT_RST;
`endif

  rv32_arb_pick2 u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_sel    (gnt_sel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (gnt_valid) state_d = (gnt_sel == GNT_D) ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: if (m_ack) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Memory-side registers load on a grant and clear their control bits on
  // completion; address and write data are left holding their last values.
  always_comb begin
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    if (grant) begin
      m_req_d = 1'b1;
      if (gnt_sel == GNT_D) begin
        m_we_d    = d_we;
        m_addr_d  = d_addr;
        m_wdata_d = d_wdata;
        m_wstrb_d = d_we ? d_wstrb : '0;
      end else begin
        m_we_d    = 1'b0;
        m_addr_d  = i_addr;
        m_wstrb_d = '0;
      end
    end else if ((state_q != IDLE) && m_ack) begin
      m_req_d   = 1'b0;
      m_we_d    = 1'b0;
      m_wstrb_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  always_comb begin
    i_ack   = (state_q == BUSY_I) && m_ack;
    d_ack   = (state_q == BUSY_D) && m_ack;
    i_rdata = i_ack ? m_rdata : '0;
    d_rdata = d_ack ? m_rdata : '0;
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign dbg_state = state_q;

`ifndef SYNTHESIS
  // Handshake: a requester holds req (and its fields) from the cycle it is
  // sampled until its ack; the memory only acks while m_req is high.
  a_i_req_held: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == BUSY_I) |-> i_req) else $error("i_req dropped while BUSY_I");
  a_d_req_held: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == BUSY_D) |-> d_req) else $error("d_req dropped while BUSY_D");
  a_no_idle_ack: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == IDLE) |-> !m_ack) else $error("m_ack seen while IDLE");
`endif

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: table of single transactions, tie/round-robin
// sequences, wait states and reset mid-transaction, against a memory model.
module tb_rv32_mem_arbiter;
  import rv32_mem_arb_pkg::*;

`ifdef RV32_MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        side;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  typedef struct {
    logic        side;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_c;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk, reset_n;
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb, m_wstrb;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  arb_state_t  dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      mem_img [0:255];
  int               mem_wait, mem_cnt;
  int               checks, errors;
  logic             tb_last;
  exp_t             mon_e;
  vec_t             vecs[9];

  rv32_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ack(m_ack),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic side, input logic we, input logic [3:0] wstrb,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata);
    exp_t e;
    e.side = side; e.we = we; e.wstrb = we ? wstrb : 4'h0;
    e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    return e;
  endfunction

  // memory model: acks after mem_wait cycles of m_req, garbage rdata otherwise
  always @(posedge clk) begin
    #1;
    if (!m_req) begin
      m_ack   = 1'b0;
      m_rdata = $urandom;
      mem_cnt = 0;
    end else if (mem_cnt == mem_wait) begin
      m_ack   = 1'b1;
      m_rdata = m_we ? 32'h0 : mem_img[m_addr[9:2]];
      if (m_we)
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) mem_img[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
      mem_cnt = 0;
    end else begin
      m_ack   = 1'b0;
      m_rdata = $urandom;
      mem_cnt++;
    end
  end

  // scoreboard: pop one expected transaction per ack
  always @(negedge clk) begin
    if (!i_ack) chk("i_rdata_gated", i_rdata, 32'h0);
    if (!d_ack) chk("d_rdata_gated", d_rdata, 32'h0);
    if (i_ack || d_ack) begin
      chk("one_ack_only", {31'b0, i_ack & d_ack}, 32'h0);
      chk("ack_expected", {31'b0, exp_q.size() > 0}, 32'h1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("ack_side", {31'b0, d_ack}, {31'b0, mon_e.side});
        chk("m_addr", m_addr, mon_e.addr);
        chk("m_we", {31'b0, m_we}, {31'b0, mon_e.we});
        chk("m_wstrb", {28'b0, m_wstrb}, {28'b0, mon_e.wstrb});
        if (mon_e.we) chk("m_wdata", m_wdata, mon_e.wdata);
        chk("rdata", d_ack ? d_rdata : i_rdata, mon_e.rdata);
      end
    end
  end

  // driver: one requester alone; called and returns at posedge+#1
  task automatic run_single(input vec_t v);
    int n, stable;
    bit got;
    mem_wait = v.wait_c;
    exp_q.push_back(mk(v.side, v.we, v.wstrb, v.addr, v.wdata, v.exp_rdata));
    if (v.side == GNT_D) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    got = 1'b0; n = 0; stable = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (m_req && m_addr == v.addr) stable++;
      got = (v.side == GNT_D) ? d_ack : i_ack;
    end
    chk("ack_seen", {31'b0, got}, 32'h1);
    chk("ack_latency", n, v.wait_c + 2);
    chk("m_req_hold", stable, v.wait_c + 1);
    tb_last = v.side;
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
  endtask

  // driver: both requesters together; the fetch re-requests forever, the
  // data side re-requests only when keep_d is set
  task automatic run_both(input int n_gnt, input bit keep_d, input logic dwe,
                          input logic [31:0] daddr, input logic [31:0] dwdata,
                          input logic [3:0] dwstrb, input logic [31:0] dexp);
    logic order[$];
    logic pick, side;
    bit   pend_d;
    int   k, n, last_n;
    mem_wait = 0;
    pend_d = 1'b1;
    for (int g = 0; g < n_gnt; g++) begin
      pick = pend_d ? (RR_EN ? ~tb_last : GNT_D) : GNT_I;
      order.push_back(pick);
      if (pick == GNT_D) exp_q.push_back(mk(GNT_D, dwe, dwstrb, daddr, dwdata, dexp));
      else               exp_q.push_back(mk(GNT_I, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0050_0093));
      if (pick == GNT_D && !keep_d) pend_d = 1'b0;
      tb_last = pick;
    end
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = dwe; d_addr = daddr; d_wdata = dwdata; d_wstrb = dwstrb;
    k = 0; n = 0; last_n = 0;
    while (k < n_gnt && n < 100) begin
      @(negedge clk);
      n++;
      if (i_ack || d_ack) begin
        side = d_ack ? GNT_D : GNT_I;
        chk("grant_order", {31'b0, side}, {31'b0, order[k]});
        if (k > 0) chk("ack_spacing", n - last_n, 2);
        else       chk("first_ack_latency", n, 2);
        last_n = n;
        k++;
        @(posedge clk); #1;
        if (k == n_gnt) begin
          i_req = 1'b0; d_req = 1'b0;
        end else if (side == GNT_D && !keep_d) begin
          d_req = 1'b0;
        end
      end
    end
    chk("all_grants", k, n_gnt);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
  endtask

  initial begin
    int n;
    bit got;
    vec_t rv;
    checks = 0; errors = 0;
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    m_ack = 1'b0; m_rdata = '0;
    mem_wait = 0; mem_cnt = 0;
    tb_last = GNT_I;
    for (int a = 0; a < 256; a++) mem_img[a] = 32'h0;
    mem_img[4]   = 32'h0050_0093;
    mem_img[128] = 32'h1234_5678;

    vecs[0] = '{GNT_I, 1'b0, 32'h10,  32'h0,         4'h0, 0, 32'h0050_0093};
    vecs[1] = '{GNT_D, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 32'h0};
    vecs[2] = '{GNT_D, 1'b1, 32'h100, 32'h1122_3344, 4'h3, 1, 32'h0};
    vecs[3] = '{GNT_D, 1'b0, 32'h100, 32'h0,         4'h0, 0, 32'hDEAD_3344};
    vecs[4] = '{GNT_D, 1'b0, 32'h200, 32'h0,         4'h0, 3, 32'h1234_5678};
    vecs[5] = '{GNT_I, 1'b0, 32'h200, 32'h0,         4'h0, 2, 32'h1234_5678};
    vecs[6] = '{GNT_D, 1'b0, 32'h104, 32'h5555_5555, 4'hF, 0, 32'h0};
    vecs[7] = '{GNT_D, 1'b1, 32'h104, 32'hCAFE_F00D, 4'hC, 0, 32'h0};
    vecs[8] = '{GNT_I, 1'b0, 32'h104, 32'h0,         4'h0, 1, 32'hCAFE_0000};

    repeat (2) @(negedge clk);
    chk("rst_m_req", {31'b0, m_req}, 32'h0);
    chk("rst_m_we", {31'b0, m_we}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_m_wstrb", {28'b0, m_wstrb}, 32'h0);
    chk("rst_acks", {30'b0, i_ack, d_ack}, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    @(posedge clk); #1;
    reset_n = 1'b1;

    // tie right after reset: data first in both policies, fetch 2 cycles later
    run_both(2, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0);
    // both held continuously: RR alternates D,I,D,I; fixed gives data every time
    run_both(4, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h1234_5678);

    for (int t = 0; t < 9; t++) run_single(vecs[t]);

    for (int r = 0; r < 6; r++) begin
      rv.side   = $urandom_range(0, 1) != 0;
      rv.we     = 1'b0;
      rv.addr   = rv.side ? 32'h200 : 32'h10;
      rv.wdata  = 32'h0;
      rv.wstrb  = 4'h0;
      rv.wait_c = $urandom_range(0, 4);
      rv.exp_rdata = rv.side ? 32'h1234_5678 : 32'h0050_0093;
      run_single(rv);
    end

    // reset asserted in the very cycle the store is being acked
    mem_wait = 1;
    exp_q.push_back(mk(GNT_D, 1'b1, 4'hF, 32'h180, 32'hA5A5_A5A5, 32'h0));
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h180; d_wdata = 32'hA5A5_A5A5; d_wstrb = 4'hF;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = d_ack;
    end
    chk("rst_pre_ack", {31'b0, got}, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_m_req", {31'b0, m_req}, 32'h0);
    chk("rst_mid_d_ack", {31'b0, d_ack}, 32'h0);
    chk("rst_mid_m_we", {31'b0, m_we}, 32'h0);
    chk("rst_mid_m_wstrb", {28'b0, m_wstrb}, 32'h0);
    chk("rst_mid_state", {30'b0, dbg_state}, {30'b0, IDLE});
    d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tb_last = GNT_I;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_ack", {30'b0, i_ack, d_ack}, 32'h0);
      chk("post_rst_m_req", {31'b0, m_req}, 32'h0);
      chk("post_rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    end

    // fresh request after the abandoned one still works
    @(posedge clk); #1;
    run_single(vecs[0]);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
